// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store slave with WAIT_CYCLES wait states.
// Define DMEM_ERR_EN for misalignment/out-of-range faults; otherwise accesses force-align and wrap.
module dmem_responder #(
  parameter int DEPTH_WORDS = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int AW = $clog2(8*DEPTH_WORDS);
  localparam int IW = (AW > 3) ? AW-3 : 1;
  localparam logic [60:0] NWORDS  = 61'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
`ifdef DMEM_ERR_EN
  localparam logic [63:0] LIMIT = 64'(8*DEPTH_WORDS);
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic        write;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
  } req_t;

  state_t                         state;
  logic [3:0]                     cnt;
  req_t                           req_q, acc;
  logic [DEPTH_WORDS-1:0][63:0]   mem;
  logic [63:0]                    rdata_q;
  logic                           err_q;

  logic [2:0]    off, amask;
  logic [7:0]    be_base, be;
  logic [63:0]   bmask, lmask, wshift, word, ld, merged;
  logic [60:0]   widx_full;
  logic [IW-1:0] widx;
  logic          acc_err, exec_c;

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // With zero wait states the access executes on the acceptance edge, so it
  // must see the live request rather than the not-yet-captured copy.
  always_comb begin
    acc       = req_q;
    if (state == IDLE) begin
      acc.write = req_write_i;
      acc.addr  = req_addr_i;
      acc.size  = req_size_i;
      acc.wdata = req_wdata_i;
    end
  end

  always_comb begin
    be_base = 8'hFF;
    amask   = 3'b111;
    case (acc.size)
      2'd0:    begin be_base = 8'h01; amask = 3'b000; end
      2'd1:    begin be_base = 8'h03; amask = 3'b001; end
      2'd2:    begin be_base = 8'h0F; amask = 3'b011; end
      default: begin be_base = 8'hFF; amask = 3'b111; end
    endcase
`ifdef DMEM_ERR_EN
    off     = acc.addr[2:0];
    acc_err = (|(off & amask)) || (acc.addr >= LIMIT);
`else
    off     = acc.addr[2:0] & ~amask;
    acc_err = 1'b0;
`endif
    widx_full = acc.addr[63:3] % NWORDS;
    widx      = widx_full[IW-1:0];
    be        = be_base << off;
    for (int b = 0; b < 8; b++) begin
      bmask[8*b +: 8] = {8{be[b]}};
      lmask[8*b +: 8] = {8{be_base[b]}};
    end
    wshift = acc.wdata << {off, 3'b000};
    word   = mem[widx];
    ld     = (word >> {off, 3'b000}) & lmask;
    merged = (word & ~bmask) | (wshift & bmask);
    exec_c = ((state == IDLE) && req_valid_i && (WAIT_CYCLES == 0)) ||
             ((state == WAIT) && (cnt == 4'd1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      mem     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          req_q <= acc;
          if (WAIT_CYCLES == 0) state <= RESP;
          else begin
            cnt   <= WAIT_LD;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (exec_c) begin
        if (acc.write && !acc_err) mem[widx] <= merged;
        rdata_q <= (acc.write || acc_err) ? 64'd0 : ld;
        err_q   <= acc_err;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;
  localparam int W     = 2;
  localparam int DEPTH = 16;
  localparam int NB    = 8*DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int total = 0;
  int bad   = 0;
  logic [7:0] mem_m [NB];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
  endtask

  // Reference: byte-addressed storage, accesses as n consecutive bytes.
  task automatic model(input logic w, input logic [63:0] a, input logic [1:0] sz,
                       input logic [63:0] wd, output logic [63:0] rd, output logic e);
    longint unsigned n, base;
    n  = 64'd1 << sz;
    rd = '0;
    e  = 1'b0;
`ifdef DMEM_ERR_EN
    if ((a % n) != 0 || a >= 64'(NB)) begin
      e = 1'b1;
      return;
    end
    base = a;
`else
    base = (a - (a % n)) % 64'(NB);
`endif
    for (int i = 0; i < int'(n); i++) begin
      if (w) mem_m[int'(base) + i] = wd[8*i +: 8];
      else   rd[8*i +: 8] = mem_m[int'(base) + i];
    end
  endtask

  task automatic xact(input logic w, input logic [63:0] a, input logic [1:0] sz,
                      input logic [63:0] wd, input int bp, output logic [63:0] rd_o);
    logic [63:0] erd, hold;
    logic        eerr;
    int          lat;
    model(w, a, sz, wd, erd, eerr);
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz; req_wdata = wd;
    rsp_ready = (bp == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(W+1));
    chk("rdata", rsp_rdata, erd);
    chk("err", 64'(rsp_err), 64'(eerr));
    rd_o = rsp_rdata;
    if (bp > 0) begin
      hold = rsp_rdata;
      repeat (bp) begin
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = '0; req_size = 2'd3; req_wdata = '1;
        @(posedge clk); #1;
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_rdata", rsp_rdata, hold);
        chk("bp_req_ready", 64'(req_ready), 64'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("back_idle", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] r, a;
    logic [1:0]  sz;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_wdata = '0; rsp_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);

    xact(1'b0, 64'h0, 2'd3, 64'h0, 0, r);
    chk("load0_lit", r, 64'h0);
    xact(1'b1, 64'h8, 2'd3, 64'h1122334455667788, 0, r);
    chk("store_rdata_zero", r, 64'h0);
    xact(1'b0, 64'h8, 2'd3, 64'h0, 0, r);
    chk("dword_lit", r, 64'h1122334455667788);
    xact(1'b1, 64'hB, 2'd0, 64'hAA, 0, r);
    xact(1'b0, 64'h8, 2'd3, 64'h0, 0, r);
    chk("merge_lit", r, 64'h11223344AA667788);
    xact(1'b0, 64'hA, 2'd1, 64'h0, 0, r);
    chk("half_lit", r, 64'h000000000000AA66);
    xact(1'b0, 64'h8, 2'd3, 64'h0, 5, r);
    chk("bp_lit", r, 64'h11223344AA667788);

`ifdef DMEM_ERR_EN
    xact(1'b0, 64'h6, 2'd2, 64'h0, 0, r);
    chk("mis_rdata_lit", r, 64'h0);
    xact(1'b1, 64'h80, 2'd3, 64'hDEADBEEFDEADBEEF, 0, r);
    xact(1'b0, 64'h0, 2'd3, 64'h0, 0, r);
    chk("oor_no_write", r, 64'h0);
`else
    xact(1'b1, 64'h80, 2'd3, 64'hDEADBEEFDEADBEEF, 0, r);
    xact(1'b0, 64'h0, 2'd3, 64'h0, 0, r);
    chk("wrap_write", r, 64'hDEADBEEFDEADBEEF);
`endif

    // Reset while a store sits in its wait states.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10; req_size = 2'd0; req_wdata = 64'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk); rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    xact(1'b0, 64'h10, 2'd0, 64'h0, 0, r);
    chk("midrst_lit", r, 64'h0);

    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = {32'($urandom), 32'($urandom)};
      else a = 64'($urandom_range(0, NB + 31));
      xact(1'($urandom_range(0, 1)), a, sz, {32'($urandom), 32'($urandom)},
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
